alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; all values below are for WIDTH=8.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  operands and instruction are valid this cycle.
REQ-005 Port: instruction  input  3  opcode select.
REQ-006 Port: A  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 Port: B  input  WIDTH  operand B, unsigned or two's complement.
REQ-008 Port: result  output  WIDTH  registered operation result.
REQ-009 Port: out_valid  output  1  result and flags are valid this cycle.
REQ-010 Ports, present only with ALU_FLAGS_EN: zero, carry, overflow, negative  output  1 each  registered status flags.

Function
REQ-011 Opcode 000 shall give result = A + B, mod 2^WIDTH.
REQ-012 Opcode 001 shall give result = A - B, mod 2^WIDTH.
REQ-013 Opcode 010 shall give result = A & B; opcode 011 shall give A | B.
REQ-014 Opcode 100 shall give result = A ^ B; opcode 101 shall give ~A, with B ignored.
REQ-015 Opcode 110 shall give A << 1 with zero fill; opcode 111 shall give A >> 1 (logical, zero fill).
REQ-016 Latency: exactly 1 cycle. Inputs sampled at a clk rising edge with in_valid=1 shall appear on result/flags after that edge, with out_valid=1.
REQ-017 When in_valid=0 at an edge, out_valid shall go 0 and result/flags shall hold their previous values.
REQ-018 No backpressure: a new operation may be accepted every cycle; back-to-back inputs shall produce back-to-back outputs.
REQ-019 All opcodes are defined; no opcode value shall produce X or hold behaviour.

Reset
REQ-020 rst_n low shall immediately, without waiting for clk, force result=0, out_valid=0 and all flags=0.
REQ-021 While rst_n is low, inputs shall be ignored.
REQ-022 The first operation is accepted at the first rising clk edge after rst_n deasserts.
REQ-023 Reset asserted while an operation is in flight shall discard that operation; no out_valid pulse shall follow.

Configuration
REQ-024 Macro ALU_FLAGS_EN defined: the four flag ports exist and are registered with result.
REQ-025 zero: set when result == 0.
REQ-026 negative: set to result[WIDTH-1].
REQ-027 carry: carry-out for ADD; borrow (A < B unsigned) for SUB; bit shifted out for shifts; 0 for logic ops.
REQ-028 overflow: signed overflow for ADD/SUB only; 0 for all other opcodes.
REQ-029 Macro ALU_FLAGS_EN undefined: the flag ports and their logic shall be absent. result and out_valid behaviour shall be unchanged.

Verification
REQ-030 Reset: assert rst_n=0 mid-operation -> result=0x00 and out_valid=0 immediately; no out_valid pulse after release.
REQ-031 A=0x1D, B=0x0E, opcodes 000..111 back-to-back with in_valid=1 -> results 0x2B, 0x0F, 0x0C, 0x1F, 0x13, 0xE2, 0x3A, 0x0E on consecutive cycles, out_valid=1 throughout.
REQ-032 A=0x0F, B=0xF0: ADD -> 0xFF, carry=0, negative=1; SUB -> 0x1F, carry=1; SHR -> 0x07, carry=1.
REQ-033 A=0x55, B=0xAA, ADD -> 0xFF, overflow=0; A=0x7F, B=0x01, ADD -> 0x80, overflow=1, negative=1.
REQ-034 A=0xCC, B=0x33: AND -> 0x00, zero=1; SHL -> 0x98, carry=1; OR -> 0xFF, zero=0.
REQ-035 in_valid=0 for 3 cycles after an operation -> out_valid=0 and result holds its last value.

Source files
------------

// File: rtl/alu.sv
// Pipelined ALU: one registered result per accepted operation, 1-cycle latency.
// Define ALU_FLAGS_EN to add registered zero/carry/overflow/negative status outputs.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       instruction,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
`endif
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             out_valid_reg;

    always_comb begin
        result_next = '0;
        case (op_e'(instruction))
            OP_ADD:  result_next = A + B;
            OP_SUB:  result_next = A - B;
            OP_AND:  result_next = A & B;
            OP_OR:   result_next = A | B;
            OP_XOR:  result_next = A ^ B;
            OP_NOT:  result_next = ~A;
            OP_SHL:  result_next = {A[WIDTH-2:0], 1'b0};
            OP_SHR:  result_next = {1'b0, A[WIDTH-1:1]};
            default: result_next = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           carry_next;
    logic           overflow_next;
    logic           zero_reg, carry_reg, overflow_reg, negative_reg;

    // Extended-width add/sub exposes carry-out and borrow in the top bit.
    always_comb begin
        sum_ext       = {1'b0, A} + {1'b0, B};
        diff_ext      = {1'b0, A} - {1'b0, B};
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (op_e'(instruction))
            OP_ADD: begin
                carry_next    = sum_ext[WIDTH];
                overflow_next = (A[WIDTH-1] == B[WIDTH-1]) &&
                                (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                carry_next    = diff_ext[WIDTH];
                overflow_next = (A[WIDTH-1] != B[WIDTH-1]) &&
                                (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SHL:  carry_next = A[WIDTH-1];
            OP_SHR:  carry_next = A[0];
            default: begin
                carry_next    = 1'b0;
                overflow_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            negative_reg <= 1'b0;
        end else if (in_valid) begin
            zero_reg     <= (result_next == '0);
            carry_reg    <= carry_next;
            overflow_reg <= overflow_next;
            negative_reg <= result_next[WIDTH-1];
        end
    end

    assign zero     = zero_reg;
    assign carry    = carry_reg;
    assign overflow = overflow_reg;
    assign negative = negative_reg;
`endif

    // Idle cycles drop out_valid but keep the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                result_reg <= result_next;
            end
        end
    end

    assign result    = result_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes one expected entry per cycle, monitor pops after each edge.
// Flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] instruction;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] result;
    logic       out_valid;
`ifdef ALU_FLAGS_EN
    logic       zero, carry, overflow, negative;
`endif

    alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .result      (result),
`ifdef ALU_FLAGS_EN
        .zero        (zero),
        .carry       (carry),
        .overflow    (overflow),
        .negative    (negative),
`endif
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flags packed as {zero, carry, overflow, negative}.
    typedef struct packed {
        logic       v;
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_r = 8'h00;
    logic [3:0] last_f = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input logic [2:0] ins, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [3:0] ef);
        A = a; B = b; instruction = ins; in_valid = 1'b1;
        q.push_back('{1'b1, er, ef});
        last_r = er; last_f = ef;
        $display("issue op=%b A=%02h B=%02h expect result=%02h flags=%b", ins, a, b, er, ef);
    endtask

    task automatic op(input logic [2:0] ins, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef);
        @(negedge clk);
        set_op(ins, a, b, er, ef);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom); instruction = 3'($urandom);
        q.push_back('{1'b0, last_r, last_f});
        $display("idle expect hold result=%02h", last_r);
    endtask

    // Monitor: one popped entry per edge while the driver has stimulus outstanding.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.v));
                check(e.v ? "result" : "result_hold", 32'(result), 32'(e.r));
`ifdef ALU_FLAGS_EN
                check("flags_zcon", 32'({zero, carry, overflow, negative}), 32'(e.f));
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; instruction = 3'b000; A = 8'h11; B = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'h00);
        check("reset_out_valid", 32'(out_valid), 32'h0);

        // First operation accepted on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        set_op(3'b000, 8'h1D, 8'h0E, 8'h2B, 4'b0000);
        op(3'b001, 8'h1D, 8'h0E, 8'h0F, 4'b0000);
        op(3'b010, 8'h1D, 8'h0E, 8'h0C, 4'b0000);
        op(3'b011, 8'h1D, 8'h0E, 8'h1F, 4'b0000);
        op(3'b100, 8'h1D, 8'h0E, 8'h13, 4'b0000);
        op(3'b101, 8'h1D, 8'h0E, 8'hE2, 4'b0001);
        op(3'b110, 8'h1D, 8'h0E, 8'h3A, 4'b0000);
        op(3'b111, 8'h1D, 8'h0E, 8'h0E, 4'b0100);

        op(3'b000, 8'h0F, 8'hF0, 8'hFF, 4'b0001);
        op(3'b001, 8'h0F, 8'hF0, 8'h1F, 4'b0100);
        op(3'b111, 8'h0F, 8'hF0, 8'h07, 4'b0100);
        op(3'b000, 8'h55, 8'hAA, 8'hFF, 4'b0001);
        op(3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011);
        op(3'b010, 8'hCC, 8'h33, 8'h00, 4'b1000);
        op(3'b110, 8'hCC, 8'h33, 8'h98, 4'b0101);
        op(3'b011, 8'hCC, 8'h33, 8'hFF, 4'b0001);
        op(3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100);
        op(3'b001, 8'h40, 8'h40, 8'h00, 4'b1000);
        op(3'b001, 8'h80, 8'h01, 8'h7F, 4'b0010);
        op(3'b101, 8'h00, 8'h5A, 8'hFF, 4'b0001);

        repeat (3) idle();

        op(3'b100, 8'hA5, 8'h0F, 8'hAA, 4'b0001);

        // Reset lands before the next edge: the pending operation must never emerge.
        @(negedge clk);
        A = 8'h12; B = 8'h34; instruction = 3'b000; in_valid = 1'b1;
        q.push_back('{1'b0, 8'h00, 4'h0});
        last_r = 8'h00; last_f = 4'h0;
        $display("issue op=000 A=12 B=34 then reset before edge");
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_result", 32'(result), 32'h00);
        check("async_reset_out_valid", 32'(out_valid), 32'h0);
`ifdef ALU_FLAGS_EN
        check("async_reset_flags", 32'({zero, carry, overflow, negative}), 32'h0);
`endif
        @(negedge clk);
        q.push_back('{1'b0, 8'h00, 4'h0});
        $display("reset held, inputs ignored");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        q.push_back('{1'b0, 8'h00, 4'h0});
        $display("reset released, expect no out_valid pulse");
        repeat (2) idle();
        op(3'b000, 8'h01, 8'h02, 8'h03, 4'b0000);
        idle();

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
